// File: rtl/rf_text_fetch.sv
// rf_text_fetch: row burst reader from text RAM port B into a credit-gated cell FIFO.
// Optional stall statistics: define RF_TEXT_FETCH_STATS_EN.
module rf_text_fetch #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADR_W      = 13,
  parameter int COLS_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADR_W-1:0]  base_adr_i,
  input  logic [COLS_W-1:0] cols_i,
  output logic              ram_cs_o,
  output logic [ADR_W-1:0]  ram_adr_o,
  input  logic [63:0]       ram_dat_i,
  output logic [63:0]       cell_o,
  output logic              cell_valid_o,
  input  logic              cell_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       stall_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADR_W-1:0]  r_adr;
  logic [COLS_W-1:0] r_issue;
  logic [COLS_W-1:0] r_pop;
  logic              r_rd_pend;
  logic              r_zdone;
  logic [CW-1:0]     r_count;
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [63:0]       r_mem [FIFO_DEPTH];

  logic          w_pop;
  logic          w_push;
  logic [CW:0]   w_used;
  logic          w_credit;
  logic          w_cs;
  logic          w_done;

  assign w_pop    = (r_count != '0) && cell_ready_i;
  assign w_push   = r_rd_pend;
  // words in the FIFO plus the one in flight, less any pop this cycle
  assign w_used   = {1'b0, r_count}
                  + {{CW{1'b0}}, r_rd_pend}
                  - {{CW{1'b0}}, w_pop};
  assign w_credit = w_used < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    w_next = r_state;
    w_cs   = 1'b0;
    w_done = r_zdone;
    unique case (r_state)
      IDLE: w_next = IDLE;
      FETCH: begin
        w_cs = (r_issue != '0) && w_credit && !start_i;
        if (r_issue == '0) w_next = DRAIN;
      end
      DRAIN: begin
        if (r_pop == '0) begin
          w_next = IDLE;
          w_done = !start_i;
        end
      end
      default: w_next = IDLE;
    endcase
    if (start_i) w_next = (cols_i != '0) ? FETCH : IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_adr     <= '0;
      r_issue   <= '0;
      r_pop     <= '0;
      r_rd_pend <= 1'b0;
      r_zdone   <= 1'b0;
      r_count   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
    end else begin
      r_state <= w_next;
      r_zdone <= 1'b0;
      if (start_i) begin
        r_adr     <= base_adr_i;
        r_issue   <= cols_i;
        r_pop     <= cols_i;
        r_rd_pend <= 1'b0;
        r_zdone   <= (cols_i == '0);
        r_count   <= '0;
        r_wptr    <= '0;
        r_rptr    <= '0;
      end else begin
        r_rd_pend <= w_cs;
        if (w_cs) begin
          r_adr   <= r_adr + ADR_W'(1);
          r_issue <= r_issue - COLS_W'(1);
        end
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop) begin
          r_rptr <= r_rptr + AW'(1);
          if (r_pop != '0) r_pop <= r_pop - COLS_W'(1);
        end
        if (w_push && !w_pop) r_count <= r_count + CW'(1);
        else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= ram_dat_i;
  end

  assign ram_cs_o     = w_cs;
  assign ram_adr_o    = r_adr;
  assign cell_valid_o = (r_count != '0);
  assign cell_o       = cell_valid_o ? r_mem[r_rptr] : 64'h0;
  assign busy_o       = (r_state != IDLE);
  assign done_o       = w_done;

`ifdef RF_TEXT_FETCH_STATS_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall <= '0;
    end else if (start_i) begin
      r_stall <= '0;
    end else if (r_state == FETCH && r_issue != '0 &&
                 !w_credit && r_stall != 16'hFFFF) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall;
`else
  assign stall_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_rf_text_fetch.sv
// tb_rf_text_fetch: directed + random row fetches against a queue-based
// transaction model of the text fetch engine.
module tb_rf_text_fetch;

  localparam int DEPTH = 8;
  localparam int AMOD  = 8192;
`ifdef RF_TEXT_FETCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [12:0] base_adr_i;
  logic [7:0]  cols_i;
  logic        ram_cs_o;
  logic [12:0] ram_adr_o;
  logic [63:0] ram_dat_i;
  logic [63:0] cell_o;
  logic        cell_valid_o;
  logic        cell_ready_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] stall_cnt_o;

  rf_text_fetch dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .base_adr_i  (base_adr_i),
    .cols_i      (cols_i),
    .ram_cs_o    (ram_cs_o),
    .ram_adr_o   (ram_adr_o),
    .ram_dat_i   (ram_dat_i),
    .cell_o      (cell_o),
    .cell_valid_o(cell_valid_o),
    .cell_ready_i(cell_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [AMOD];

  // RAM port B: one-cycle read latency
  always @(posedge clk) begin
    if (ram_cs_o) ram_dat_i <= mem[ram_adr_o];
  end

  int n_vec, n_err;
  int mode;
  logic [63:0] exp_q [$];
  int issued, popped, cols_m, base_m, stall_m;
  bit row_busy, zdone, prev_cs;
  int first_pop_iss;
  int n_done;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    issued = 0; popped = 0; cols_m = 0; base_m = 0;
    stall_m = 0; row_busy = 0; zdone = 0; prev_cs = 0;
    first_pop_iss = -1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cs"}, 64'(ram_cs_o), 64'd0);
    chk({tag, "_adr"}, 64'(ram_adr_o), 64'd0);
    chk({tag, "_valid"}, 64'(cell_valid_o), 64'd0);
    chk({tag, "_cell"}, cell_o, 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_stall"}, 64'(stall_cnt_o), 64'd0);
  endtask

  // one clock cycle: inputs set at posedge+1, checked and modelled at negedge
  task automatic cyc();
    bit e_valid, e_pop, e_cs, e_done, blocked, fetching;
    int outst;
    unique case (mode)
      0: cell_ready_i = 1'b1;
      1: cell_ready_i = ($urandom_range(0, 3) != 0);
      default: cell_ready_i = 1'b0;
    endcase
    @(negedge clk);
    e_valid  = (issued - popped - int'(prev_cs)) > 0;
    e_pop    = e_valid && cell_ready_i;
    outst    = issued - popped - int'(e_pop);
    fetching = row_busy && issued < cols_m && !start_i;
    blocked  = outst >= DEPTH;
    e_cs     = fetching && !blocked;
    e_done   = zdone || (row_busy && popped == cols_m && !start_i);
    chk("cs", 64'(ram_cs_o), 64'(e_cs));
    if (e_cs) chk("adr", 64'(ram_adr_o), 64'((base_m + issued) % AMOD));
    chk("valid", 64'(cell_valid_o), 64'(e_valid));
    if (e_valid) chk("cell", cell_o, exp_q[0]);
    chk("busy", 64'(busy_o), 64'(row_busy));
    chk("done", 64'(done_o), 64'(e_done));
    chk("stall", 64'(stall_cnt_o), STATS ? 64'(stall_m) : 64'd0);
    if (done_o) n_done++;
    if (fetching && blocked && stall_m < 65535) stall_m++;
    if (e_pop) begin
      if (popped == 0 && first_pop_iss < 0) first_pop_iss = issued;
      void'(exp_q.pop_front());
      popped++;
    end
    if (e_cs) issued++;
    prev_cs = e_cs;
    if (e_done) row_busy = 0;
    zdone = 0;
    if (start_i) begin
      exp_q.delete();
      base_m = int'(base_adr_i);
      cols_m = int'(cols_i);
      for (int i = 0; i < cols_m; i++) exp_q.push_back(mem[(base_m + i) % AMOD]);
      issued = 0; popped = 0; prev_cs = 0; stall_m = 0;
      first_pop_iss = -1;
      row_busy = (cols_m != 0);
      zdone = (cols_m == 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_row(input int base, input int cols);
    start_i    = 1'b1;
    base_adr_i = 13'(base);
    cols_i     = 8'(cols);
    cyc();
    start_i    = 1'b0;
    base_adr_i = 13'($urandom);
    cols_i     = 8'($urandom);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    while ((row_busy || zdone) && k < max) begin
      cyc();
      k++;
    end
    if (row_busy || zdone) begin
      n_vec++;
      n_err++;
      $error("FAIL idle_timeout: observed busy after %0d cycles, expected idle", max);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_done = 0; mode = 0;
    rst_ni = 1'b0; start_i = 1'b0; base_adr_i = '0; cols_i = '0;
    cell_ready_i = 1'b0;
    for (int i = 0; i < AMOD; i++) mem[i] = {$urandom, $urandom};
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_ni = 1'b1;
    run(2);

    // 1: free-running consumer, 80 cells from 0x0100
    mode = 0;
    start_row(16'h0100, 80);
    wait_idle(300);
    run(2);

    // 2: consumer stalled 30 cycles after start
    mode = 2;
    start_row(16'h0400, 20);
    run(30);
    mode = 0;
    wait_idle(300);
    chk("t2_iss_before_pop", 64'(first_pop_iss), 64'd8);
    chk("t2_stall_total", 64'(stall_cnt_o), STATS ? 64'd22 : 64'd0);
    run(2);

    // 3: address wrap
    mode = 1;
    start_row(16'h1FFE, 4);
    wait_idle(100);
    run(2);

    // 4: zero columns
    start_row(16'h0222, 0);
    run(4);

    // 5: restart at cell 5 of a 40-cell row
    mode = 0;
    n_done = 0;
    start_row(16'h0300, 40);
    for (int k = 0; k < 100 && popped < 5; k++) cyc();
    start_row(16'h0800, 3);
    wait_idle(100);
    run(2);
    chk("t5_done_pulses", 64'(n_done), 64'd1);

    // 6: reset mid-burst
    mode = 0;
    start_row(16'h0555, 50);
    run(10);
    rst_ni = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    run(5);

    // random rows, some restarted mid-flight
    for (int r = 0; r < 12; r++) begin
      mode = int'($urandom_range(0, 1));
      start_row(int'($urandom_range(0, AMOD - 1)), int'($urandom_range(1, 60)));
      if ($urandom_range(0, 3) == 0) begin
        run(int'($urandom_range(2, 15)));
        start_row(int'($urandom_range(0, AMOD - 1)), int'($urandom_range(1, 30)));
      end
      wait_idle(2000);
      run(int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
